// File: rtl/vc_fifo.sv
// vc_fifo: router input buffer with NUM_VC independent circular FIFOs behind one write port and one read port.
// Output data is registered, with a one-cycle read latency. Per-VC flags are decoded from registered counts.
module vc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int NUM_VC = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in,
  input  logic                    wr_en,
  input  logic [VC_W-1:0]         wr_vc,
  input  logic                    rd_en,
  input  logic [VC_W-1:0]         rd_vc,
  output logic [DATA_W-1:0]       out,
  output logic                    out_valid,
  output logic [VC_W-1:0]         out_vc,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC*CNT_W-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [AW-1:0] wptr_q [NUM_VC];
  logic [AW-1:0] wptr_d [NUM_VC];
  logic [AW-1:0] rptr_q [NUM_VC];
  logic [AW-1:0] rptr_d [NUM_VC];
  logic [CNT_W-1:0] cnt_q [NUM_VC];
  logic [CNT_W-1:0] cnt_d [NUM_VC];
  logic [DATA_W-1:0] out_q, out_d;
  logic [VC_W-1:0] out_vc_q, out_vc_d;
  logic out_valid_q, out_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = wr_en && (32'(wr_vc) < NUM_VC) && !full[wr_vc];
    rd_ok = rd_en && (32'(rd_vc) < NUM_VC) && !empty[rd_vc];
    for (int v = 0; v < NUM_VC; v++) begin
      wptr_d[v] = wptr_q[v] + AW'(wr_ok && wr_vc == VC_W'(v));
      rptr_d[v] = rptr_q[v] + AW'(rd_ok && rd_vc == VC_W'(v));
      cnt_d[v] = cnt_q[v] + CNT_W'(wr_ok && wr_vc == VC_W'(v)) - CNT_W'(rd_ok && rd_vc == VC_W'(v));
    end
    out_d = rd_ok ? mem_q[rd_vc][rptr_q[rd_vc]] : out_q;
    out_vc_d = rd_ok ? rd_vc : out_vc_q;
    out_valid_d = rd_ok;
    overflow_d = overflow_q | (wr_en & ~wr_ok);
    underflow_d = underflow_q | (rd_en & ~rd_ok);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        cnt_q[v] <= '0;
      end
      out_q <= '0;
      out_vc_q <= '0;
      out_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      out_vc_q <= out_vc_d;
      out_valid_q <= out_valid_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wr_vc][wptr_q[wr_vc]] <= in;
  end
  for (genvar g = 0; g < NUM_VC; g++) begin : g_flags
    assign empty[g] = cnt_q[g] == '0;
    assign full[g] = cnt_q[g] == CNT_W'(DEPTH);
    assign almost_full[g] = cnt_q[g] >= CNT_W'(AF_LEVEL);
    assign count[g*CNT_W +: CNT_W] = cnt_q[g];
  end
  assign out = out_q;
  assign out_vc = out_vc_q;
  assign out_valid = out_valid_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-virtual-channel input buffer for a router input port. One shared write port and one shared read port address NUM_VC independent circular FIFOs, each DEPTH entries of DATA_W bits. Per-VC empty/full/almost-full flags and occupancy counts drive credit-based flow control and the VC allocator. Output data is registered with a one-cycle read latency, and write/read pointers wrap per VC.

## Interface

Parameters:
- DATA_W, 8: flit width in bits.
- DEPTH, 16: entries per VC; power of two, at least 2.
- NUM_VC, 4: number of virtual channels, at least 1.
- AF_LEVEL, DEPTH-2: almost-full threshold; almost_full[v] = (count_v >= AF_LEVEL).

Derived widths:
- VC_W = max(1, clog2(NUM_VC)).
- CNT_W = clog2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; state clears at a clk edge where reset==0.
- in  in  DATA_W  write data.
- wr_en  in  1  write request.
- wr_vc  in  VC_W  target VC of the write.
- rd_en  in  1  read request.
- rd_vc  in  VC_W  source VC of the read.
- out  out  DATA_W  registered read data.
- out_valid  out  1  out holds data popped at the previous edge.
- out_vc  out  VC_W  VC that out came from.
- empty  out  NUM_VC  per-VC empty, bit v = VC v.
- full  out  NUM_VC  per-VC full.
- almost_full  out  NUM_VC  per-VC count >= AF_LEVEL.
- count  out  NUM_VC*CNT_W  per-VC occupancy; VC v occupies bits [v*CNT_W +: CNT_W].
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation

- Each VC v has a write pointer, a read pointer (clog2(DEPTH) bits each, natural wrap DEPTH-1→0) and a count (0..DEPTH).
- **Write acceptance:** a write is accepted when wr_en=1, wr_vc<NUM_VC and full[wr_vc]=0, using the flag value before the edge.
  - On accept: mem[wr_vc][wptr] <= in, wptr++.
  - Otherwise the write is dropped and overflow is set.
- **Read acceptance:** a read is accepted when rd_en=1, rd_vc<NUM_VC and empty[rd_vc]=0.
  - On accept: out <= mem[rd_vc][rptr], out_vc <= rd_vc, out_valid <= 1, rptr++.
  - Otherwise out_valid <= 0, out and out_vc hold their values, and underflow is set.
- **No read requested** (rd_en=0): out_valid <= 0; out and out_vc hold.
- **Count update, per VC:** +1 on an accepted write only, -1 on an accepted read only, unchanged if both or neither.
- **Simultaneous accepted write and read, same VC:** both take effect and the count is unchanged.
  - On a full VC the write is rejected even if a read of that VC is accepted the same edge (no pass-through); count becomes DEPTH-1.
  - On an empty VC the read is rejected even if a write is accepted the same edge; count becomes 1.
- **Different VCs:** a write and a read to different VCs are fully independent.
- **Flags:** empty, full and almost_full are combinational decodes of the registered counts: empty = (count==0), full = (count==DEPTH).
- **Reset** (reset==0 at an edge), including mid-operation:
  - all pointers and counts go to 0;
  - out = 0, out_vc = 0, out_valid = 0;
  - overflow = 0, underflow = 0;
  - memory contents are not cleared.
- **After reset:** empty = all ones, full = 0, almost_full = 0 (AF_LEVEL>0), count = 0.
- **Requests during reset:** requests in a cycle with reset==0 are ignored and do not set overflow or underflow.
- **Sticky flags:** overflow and underflow clear only on reset.

## Timing

- Write latency: data written at edge N is readable by a read requested in cycle N+1, accepted at edge N+1, and visible on out in cycle N+2.
- Read latency: a read accepted at edge N drives out/out_valid/out_vc from edge N, i.e. valid throughout cycle N+1.
- Flags and count reflect the state after the most recent edge; there is no combinational path from wr_en/rd_en to any flag.
- Throughput: one write and one read per cycle sustained, on any VC combination.

## Test plan

- **Reset and fill/drain:** reset, then write 0x01..0x10 to VC2 (DEPTH=16).
  - After the 16th edge: full=4'b0100, count[VC2]=16, almost_full[2]=1 from count 14.
  - Then 16 reads: out = 0x01..0x10 in order, each one cycle after its read, out_vc=2; empty[2]=1 at the end.
- **Overflow/underflow:** write to full VC2 → data dropped, overflow=1, count stays 16. Read empty VC0 → out_valid=0, underflow=1. Both stay 1 until reset.
- **Wrap-around:** 40 interleaved write/read pairs on VC1 (data = index) → out sequence 0..39 with no loss; count returns to 0 and pointers wrap twice.
- **Simultaneous events on VC3:**
  - count=5, write and read in the same cycle → count stays 5, FIFO order preserved.
  - Full VC3 with write+read → write rejected, overflow=1, count=15.
  - Empty VC3 with write+read → underflow=1, count=1, and the next read returns the written value.
- **VC isolation:** interleave writes of 0xA0+v to all four VCs, then read VC order 3,0,2,1 → out=0xA3,0xA0,0xA2,0xA1 with matching out_vc.
- **Reset mid-operation:** VC0 holding 7 entries, pull reset low for one cycle during a read.
  - Next cycle: count=0, empty=4'b1111, out=0, out_valid=0, flags cleared.
  - A subsequent write/read of 0x5A returns 0x5A.
